// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb -- word-atomic round-robin arbiter in front of the 4-bit
// write port of the small-to-big FIFO. Runs on the FIFO write clock.
//
// Ports:
//   clk, rstn        FIFO write clock, async active-low reset
//   req[NREQ]        per-requester valid
//   din_i[NREQ*DW]   requester i nibble at [i*DW +: DW]
//   gnt[NREQ]        combinational ready, one-hot or zero
//   fifo_afull       FIFO prog_full, sampled only in IDLE
//   fifo_din         registered nibble to the FIFO
//   fifo_din_en      registered write enable to the FIFO
//   owner            current or last word owner
//   busy             a word is in progress
//   to_err           one-cycle pulse with the first timeout pad nibble
//
// Optional feature: define ARB_TIMEOUT_EN to pad a stalled word with zero
// nibbles after TIMEOUT stall cycles. Without it XFER waits forever and
// to_err is tied low.
//
// state | meaning
// IDLE  | no owner; arbitrate (skipped for one cycle right after a word)
// XFER  | owner holds the port until BEAT nibbles have transferred
// PAD   | timeout only: write zero nibbles to finish the word
module fifo_wr_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int BEAT    = 4,
  parameter int TIMEOUT = 16,
  localparam int OW     = $clog2(NREQ),
  localparam int CW     = $clog2(BEAT + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din_i,
  output logic [NREQ-1:0]    gnt,
  input  logic               fifo_afull,
  output logic [DW-1:0]      fifo_din,
  output logic               fifo_din_en,
  output logic [OW-1:0]      owner,
  output logic               busy,
  output logic               to_err
);

  if (NREQ < 2 || NREQ > 8 || BEAT < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_wr_arb: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, PAD = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   last_q, last_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [DW-1:0]   fifo_din_q, fifo_din_d;
  logic            din_en_q, din_en_d;
  // Set for the cycle after a word ends; that cycle is the idle arbitration
  // slot between words, so no grant is issued in it.
  logic            done_q, done_d;
  logic            to_err_q, to_err_d;

  logic [OW-1:0]   winner;
  logic            found;
  logic [OW-1:0]   sel;
  logic            xfer;
  logic [DW-1:0]   nib;

`ifdef ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]   stall_q, stall_d;
`endif

  // Round-robin search upward from last_q + 1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last_q) + k) % NREQ]) begin
        found  = 1'b1;
        winner = OW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      last_q     <= OW'(NREQ - 1);
      owner_q    <= '0;
      fifo_din_q <= '0;
      din_en_q   <= 1'b0;
      done_q     <= 1'b0;
      to_err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      fifo_din_q <= fifo_din_d;
      din_en_q   <= din_en_d;
      done_q     <= done_d;
      to_err_q   <= to_err_d;
`ifdef ARB_TIMEOUT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  // Output logic: grant and selected nibble
  always_comb begin
    gnt = '0;
    sel = owner_q;
    case (state_q)
      IDLE: begin
        if (found && !fifo_afull && !done_q) begin
          gnt[winner] = 1'b1;
          sel         = winner;
        end
      end
      XFER:    gnt[owner_q] = 1'b1;
      default: ;
    endcase
    if (!rstn) gnt = '0;
  end

  assign xfer = |(gnt & req);
  assign nib  = din_i[int'(sel)*DW +: DW];

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    last_d     = last_q;
    owner_d    = owner_q;
    fifo_din_d = fifo_din_q;
    din_en_d   = 1'b0;
    done_d     = 1'b0;
    to_err_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_d    = stall_q;
`endif
    if (xfer) begin
      din_en_d   = 1'b1;
      fifo_din_d = nib;
    end
    case (state_q)
      IDLE: begin
        if (xfer) begin
          owner_d = winner;
          count_d = CW'(1);
          state_d = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
`ifdef ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (count_q == CW'(BEAT - 1)) begin
            count_d = '0;
            last_d  = owner_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (stall_q == SW'(TIMEOUT - 1)) begin
          // Leave stall_q at TIMEOUT so PAD can flag its first cycle.
          stall_d = SW'(TIMEOUT);
          state_d = PAD;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      PAD: begin
        din_en_d   = 1'b1;
        fifo_din_d = '0;
        to_err_d   = (stall_q == SW'(TIMEOUT));
        stall_d    = '0;
        if (count_q == CW'(BEAT - 1)) begin
          count_d = '0;
          last_d  = owner_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign fifo_din    = fifo_din_q;
  assign fifo_din_en = din_en_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
  assign to_err      = to_err_q;
`else
  assign to_err      = 1'b0;
`endif

endmodule
